// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data_memory port between fetch (I) and load/store (D).
// One access per MEM_LATENCY+2 cycles; ready pulses MEM_LATENCY+1 cycles after accept; losers wait.
module mem_port_arbiter #(
  parameter int WORD_SIZE   = 32,
  parameter int BLOCK_SIZE  = 16,
  parameter int MEM_LATENCY = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_req,
  input  logic [WORD_SIZE-1:0]            i_ptr,
  output logic                            i_ready,
  output logic [BLOCK_SIZE*WORD_SIZE-1:0] i_block,
  input  logic                            d_req,
  input  logic                            d_we,
  input  logic [WORD_SIZE-1:0]            d_ptr,
  input  logic [WORD_SIZE-1:0]            d_val,
  output logic                            d_ready,
  output logic [BLOCK_SIZE*WORD_SIZE-1:0] d_block,
  output logic                            busy,
  output logic [WORD_SIZE-1:0]            mem_ptr,
  output logic [WORD_SIZE-1:0]            mem_val,
  output logic                            mem_read_enable,
  output logic                            mem_write_enable,
  input  logic [BLOCK_SIZE*WORD_SIZE-1:0] mem_block
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic       OWN_I  = 1'b0;
  localparam logic       OWN_D  = 1'b1;
  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  state_t                        r_state;
  logic [3:0]                    r_count;
  logic                          r_last_grant;
  logic                          r_owner;
  logic                          r_we;
  logic [WORD_SIZE-1:0]          r_ptr;
  logic [WORD_SIZE-1:0]          r_val;
  logic                          r_i_ready;
  logic                          r_d_ready;
  logic                          r_busy;
  logic                          r_re;
  logic                          r_wr;
  logic [BLOCK_SIZE*WORD_SIZE-1:0] r_i_block;
  logic [BLOCK_SIZE*WORD_SIZE-1:0] r_d_block;

  state_t               w_state_nxt;
  logic [3:0]           w_count_nxt;
  logic                 w_last_nxt;
  logic                 w_owner_nxt;
  logic                 w_we_nxt;
  logic [WORD_SIZE-1:0] w_ptr_nxt;
  logic [WORD_SIZE-1:0] w_val_nxt;
  logic                 w_grant_d;
  logic                 w_capture;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_last_nxt  = r_last_grant;
    w_owner_nxt = r_owner;
    w_we_nxt    = r_we;
    w_ptr_nxt   = r_ptr;
    w_val_nxt   = r_val;
    w_capture   = 1'b0;
    // On a tie, D wins only if I was served last.
    w_grant_d   = d_req & (~i_req | (r_last_grant == OWN_I));
    case (r_state)
      S_IDLE: begin
        if (i_req || d_req) begin
          w_state_nxt = S_BUSY;
          w_count_nxt = LAT_M1;
          w_owner_nxt = w_grant_d ? OWN_D : OWN_I;
          w_ptr_nxt   = w_grant_d ? d_ptr : i_ptr;
          w_val_nxt   = w_grant_d ? d_val : '0;
          w_we_nxt    = w_grant_d & d_we;
        end
      end
      S_BUSY: begin
        if (r_count == 4'd0) begin
          w_state_nxt = S_DONE;
          w_capture   = ~r_we;
        end else begin
          w_count_nxt = r_count - 4'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_last_nxt  = r_owner;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_last_grant <= OWN_D;
      r_owner      <= OWN_I;
      r_we         <= 1'b0;
      r_ptr        <= '0;
      r_val        <= '0;
      r_i_ready    <= 1'b0;
      r_d_ready    <= 1'b0;
      r_busy       <= 1'b0;
      r_re         <= 1'b0;
      r_wr         <= 1'b0;
      r_i_block    <= '0;
      r_d_block    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_last_grant <= w_last_nxt;
      r_owner      <= w_owner_nxt;
      r_we         <= w_we_nxt;
      r_ptr        <= w_ptr_nxt;
      r_val        <= w_val_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_re         <= (w_state_nxt == S_BUSY) && !w_we_nxt;
      r_wr         <= (w_state_nxt == S_BUSY) && w_we_nxt && (w_count_nxt == 4'd0);
      r_i_ready    <= (w_state_nxt == S_DONE) && (w_owner_nxt == OWN_I);
      r_d_ready    <= (w_state_nxt == S_DONE) && (w_owner_nxt == OWN_D);
      if (w_capture && (r_owner == OWN_I)) r_i_block <= mem_block;
      if (w_capture && (r_owner == OWN_D)) r_d_block <= mem_block;
    end
  end

  assign i_ready          = r_i_ready;
  assign d_ready          = r_d_ready;
  assign i_block          = r_i_block;
  assign d_block          = r_d_block;
  assign busy             = r_busy;
  assign mem_ptr          = r_ptr;
  assign mem_val          = r_val;
  assign mem_read_enable  = r_re;
  assign mem_write_enable = r_wr;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small word-addressed memory model (word k = k).
module tb_mem_port_arbiter;
  localparam int W  = 32;
  localparam int BS = 16;
  localparam int L  = 4;
  localparam int BW = W * BS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req, d_req, d_we;
  logic [W-1:0]  i_ptr, d_ptr, d_val;
  logic          i_ready, d_ready, busy;
  logic [BW-1:0] i_block, d_block, mem_block;
  logic [W-1:0]  mem_ptr, mem_val;
  logic          mem_read_enable, mem_write_enable;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_iready = 0;
  int n_dready = 0;
  int n_we = 0;
  logic [W-1:0] we_ptr = '0;
  logic [W-1:0] we_val = '0;
  logic mem_init;
  logic [W-1:0] mem [256];

  mem_port_arbiter #(.WORD_SIZE(W), .BLOCK_SIZE(BS), .MEM_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_ptr(i_ptr), .i_ready(i_ready), .i_block(i_block),
    .d_req(d_req), .d_we(d_we), .d_ptr(d_ptr), .d_val(d_val),
    .d_ready(d_ready), .d_block(d_block), .busy(busy),
    .mem_ptr(mem_ptr), .mem_val(mem_val),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_block(mem_block)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'(k);
    end else if (mem_write_enable) begin
      mem[mem_ptr[7:0]] <= mem_val;
    end
  end

  always_comb begin
    mem_block = '0;
    for (int k = 0; k < BS; k++)
      mem_block[(BS-1-k)*W +: W] = mem[{mem_ptr[7:4], k[3:0]}];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (i_ready) n_iready <= n_iready + 1;
    if (d_ready) n_dready <= n_dready + 1;
    if (mem_write_enable) begin
      n_we   <= n_we + 1;
      we_ptr <= mem_ptr;
      we_val <= mem_val;
    end
  end

  task automatic wait_ready(input bit is_d, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      n++;
      if (is_d ? d_ready : i_ready) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [W*2+5-1:0] outs;
    rst_n = 1'b0; i_req = 0; d_req = 0; d_we = 0;
    i_ptr = '0; d_ptr = '0; d_val = '0;
    mem_init = 1'b1;
    @(negedge clk); @(negedge clk);
    mem_init = 1'b0;
    outs = {i_ready, d_ready, busy, mem_read_enable, mem_write_enable, mem_ptr, mem_val};
    tests++;
    if (outs !== '0) begin fails++; $display("FAIL reset_outs: got %h want 0", outs); end
    tests++;
    if ({i_block, d_block} !== '0) begin fails++; $display("FAIL reset_blocks: got nonzero want 0"); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_i_read();
    int n; bit ok; int d0; int bad;
    d0 = n_dready;
    i_req = 1'b1; i_ptr = 32'h23;
    wait_ready(1'b0, n, ok);
    i_req = 1'b0;
    tests++;
    if (!ok || n != L + 1) begin fails++; $display("FAIL i_latency: got %0d (ok=%0d) want %0d", n, ok, L + 1); end
    @(negedge clk);
    tests++;
    if (i_ready !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL i_pulse: got ready=%b busy=%b want 0 0", i_ready, busy);
    end
    bad = 0;
    for (int k = 0; k < BS; k++)
      if (i_block[(BS-1-k)*W +: W] !== 32'(32'h20 + k)) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL i_block: got %0d bad words, MSW %h want 0 bad, MSW 20", bad, i_block[BW-1 -: W]); end
    tests++;
    if (n_dready != d0) begin fails++; $display("FAIL i_no_dready: got %0d want %0d", n_dready, d0); end
  endtask

  task automatic test_store_load();
    int n; bit ok; int w0; logic [BW-1:0] db;
    db = d_block; w0 = n_we;
    d_req = 1'b1; d_we = 1'b1; d_ptr = 32'h10; d_val = 32'hDEADBEEF;
    wait_ready(1'b1, n, ok);
    d_req = 1'b0; d_we = 1'b0;
    tests++;
    if (!ok) begin fails++; $display("FAIL store_ready: got timeout want d_ready"); end
    tests++;
    if (n_we - w0 != 1 || we_ptr !== 32'h10) begin
      fails++; $display("FAIL store_we: got %0d strobes ptr %h want 1 strobe ptr 10", n_we - w0, we_ptr);
    end
    tests++;
    if (mem[8'h10] !== 32'hDEADBEEF) begin fails++; $display("FAIL store_mem: got %h want deadbeef", mem[8'h10]); end
    tests++;
    if (d_block !== db) begin fails++; $display("FAIL store_dblock: got changed MSW %h want %h", d_block[BW-1 -: W], db[BW-1 -: W]); end
    @(negedge clk);
    d_req = 1'b1; d_ptr = 32'h10;
    wait_ready(1'b1, n, ok);
    d_req = 1'b0;
    tests++;
    if (!ok || d_block[BW-1 -: W] !== 32'hDEADBEEF || d_block[BW-W-1 -: W] !== 32'h11) begin
      fails++; $display("FAIL load_back: got %h %h ok=%0d want deadbeef 00000011", d_block[BW-1 -: W], d_block[BW-W-1 -: W], ok);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    int ir0; logic [W*2+5-1:0] outs;
    i_req = 1'b1; i_ptr = 32'h45;
    @(negedge clk); @(negedge clk);
    ir0 = n_iready;
    rst_n = 1'b0; i_req = 1'b0;
    #1;
    outs = {i_ready, d_ready, busy, mem_read_enable, mem_write_enable, mem_ptr, mem_val};
    tests++;
    if (outs !== '0 || {i_block, d_block} !== '0) begin
      fails++; $display("FAIL midrun_reset_outs: got %h (blocks %0d) want 0", outs, {i_block, d_block} !== '0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    tests++;
    if (n_iready != ir0 || busy !== 1'b0) begin
      fails++; $display("FAIL midrun_no_ready: got %0d pulses busy=%b want %0d busy=0", n_iready, busy, ir0);
    end
  endtask

  task automatic test_alternate();
    int got; int seq[4]; int at[4]; bit bad_gap;
    got = 0;
    i_req = 1'b1; i_ptr = 32'h70;
    d_req = 1'b1; d_we = 1'b0; d_ptr = 32'h30;
    for (int k = 0; k < 60 && got < 4; k++) begin
      @(negedge clk);
      if (i_ready || d_ready) begin
        seq[got] = d_ready ? 1 : 0;
        at[got]  = cyc;
        got++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    tests++;
    if (got != 4) begin fails++; $display("FAIL alt_count: got %0d want 4", got); end
    else begin
      tests++;
      if (seq[0] != 0 || seq[1] != 1 || seq[2] != 0 || seq[3] != 1) begin
        fails++; $display("FAIL alt_order: got %0d%0d%0d%0d want 0101", seq[0], seq[1], seq[2], seq[3]);
      end
      bad_gap = 1'b0;
      for (int k = 1; k < 4; k++) if (at[k] - at[k-1] != L + 2) bad_gap = 1'b1;
      tests++;
      if (bad_gap) begin fails++; $display("FAIL alt_spacing: got %0d %0d %0d want %0d", at[1]-at[0], at[2]-at[1], at[3]-at[2], L + 2); end
    end
    tests++;
    if (i_block[BW-1 -: W] !== 32'h70 || d_block[BW-1 -: W] !== 32'h30) begin
      fails++; $display("FAIL alt_blocks: got %h %h want 70 30", i_block[BW-1 -: W], d_block[BW-1 -: W]);
    end
    @(negedge clk);
  endtask

  task automatic test_late_d();
    int n; bit ok;
    i_req = 1'b1; i_ptr = 32'h80;
    @(negedge clk); @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_ptr = 32'h90;
    @(negedge clk);
    d_ptr = 32'hA0;
    wait_ready(1'b0, n, ok);
    i_req = 1'b0;
    tests++;
    if (!ok) begin fails++; $display("FAIL late_i_ready: got timeout want i_ready"); end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL late_idle_gap: got busy=%b want 0", busy); end
    @(negedge clk);
    tests++;
    if (mem_ptr !== 32'hA0 || mem_read_enable !== 1'b1) begin
      fails++; $display("FAIL late_d_accept: got ptr %h re=%b want a0 1", mem_ptr, mem_read_enable);
    end
    wait_ready(1'b1, n, ok);
    d_req = 1'b0;
    tests++;
    if (!ok || d_block[BW-1 -: W] !== 32'hA0 || i_block[BW-1 -: W] !== 32'h80) begin
      fails++; $display("FAIL late_blocks: got d %h i %h ok=%0d want a0 80", d_block[BW-1 -: W], i_block[BW-1 -: W], ok);
    end
    @(negedge clk);
  endtask

  task automatic test_store_reset();
    int n; bit ok; int w0; int dr0;
    w0 = n_we; dr0 = n_dready;
    d_req = 1'b1; d_we = 1'b1; d_ptr = 32'h60; d_val = 32'h12345678;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0; d_req = 1'b0; d_we = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    tests++;
    if (n_we != w0 || mem[8'h60] !== 32'h60 || n_dready != dr0) begin
      fails++; $display("FAIL store_abort: got we %0d mem %h dready %0d want %0d 00000060 %0d", n_we, mem[8'h60], n_dready, w0, dr0);
    end
    d_req = 1'b1; d_ptr = 32'h60;
    wait_ready(1'b1, n, ok);
    d_req = 1'b0;
    tests++;
    if (!ok || n != L + 1 || d_block[BW-1 -: W] !== 32'h60) begin
      fails++; $display("FAIL after_abort_load: got lat %0d MSW %h ok=%0d want %0d 60", n, d_block[BW-1 -: W], ok, L + 1);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_store_load();
    test_reset_midrun();
    test_alternate();
    test_late_d();
    test_store_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end

endmodule
